// File: rtl/vga_plot_arbiter_pkg.sv
// Shared types and constants for the VGA plot arbiter.
// Screen geometry, block size and FSM state encoding.
package vga_plot_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLOCK = 2'd1,
        S_CLEAR = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int BLOCK_SIDE = 4;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam logic [2:0] CLEAR_COLOUR_DEF = 3'b000;

endpackage

// File: rtl/vga_plot_arbiter_raster_counter.sv
// Raster x/y sweep counter used by the full-screen clear.
// Counts row-major with enable, synchronous clear and last-pixel flag.
module raster_counter #(
    parameter int XW = 8,
    parameter int YW = 7,
    parameter int X_MAX = 159,
    parameter int Y_MAX = 119
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          en,
    input  logic          clr,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);

    localparam logic [XW-1:0] XL = XW'(X_MAX);
    localparam logic [YW-1:0] YL = YW'(Y_MAX);

    assign last = (x == XL) && (y == YL);

    // Step the sweep one pixel per enabled cycle, wrapping at the frame end.
    always_ff @(posedge clk) begin
        if (!resetn || clr) begin
            x <= '0;
            y <= '0;
        end else if (en) begin
            if (x == XL) begin
                x <= '0;
                y <= (y == YL) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Arbitrates the VGA plot port between two block drawers and a clear.
// Player blocks are expanded to 4x4 pixels; clear sweeps the frame.
module vga_plot_arbiter
    import vga_plot_arbiter_pkg::*;
#(
    parameter int X_MAX = SCREEN_W - 1,
    parameter int Y_MAX = SCREEN_H - 1,
    parameter logic [2:0] CLEAR_COLOUR = CLEAR_COLOUR_DEF
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    input  logic [7:0] p0_x,
    input  logic [6:0] p0_y,
    input  logic [2:0] p0_colour,
    input  logic [7:0] p1_x,
    input  logic [6:0] p1_y,
    input  logic [2:0] p1_colour,
    input  logic       clr_req,
    output logic [1:0] done,
    output logic       clr_done,
    output logic       busy,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot
);

    localparam logic [3:0] CNT_LAST = 4'(BLOCK_SIDE * BLOCK_SIDE - 1);

    state_t     state;
    state_t     state_n;
    logic [7:0] bx;
    logic [6:0] by;
    logic [2:0] bc;
    logic [3:0] cnt;
    logic       gnt;
    logic       last_grant;
    logic       clr_job;
    logic       grant_go;
    logic       grant_p;
    logic       rc_en;
    logic       rc_clr;
    logic [7:0] rx;
    logic [6:0] ry;
    logic       rc_last;
    logic [8:0] sum_x;
    logic [7:0] sum_y;
    logic       clip;

    raster_counter #(
        .XW(8),
        .YW(7),
        .X_MAX(X_MAX),
        .Y_MAX(Y_MAX)
    ) u_raster (
        .clk(clk),
        .resetn(resetn),
        .en(rc_en),
        .clr(rc_clr),
        .x(rx),
        .y(ry),
        .last(rc_last)
    );

    // Widened sums so an origin near the edge clips instead of wrapping.
    assign sum_x = {1'b0, bx} + {7'b0, cnt[1:0]};
    assign sum_y = {1'b0, by} + {6'b0, cnt[3:2]};
    assign clip  = (sum_x > 9'(X_MAX)) || (sum_y > 8'(Y_MAX));
    assign busy  = (state != S_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    // Next-state logic and arbitration: clear first, then round-robin.
    always_comb begin
        state_n  = state;
        grant_go = 1'b0;
        grant_p  = 1'b0;
        rc_en    = 1'b0;
        rc_clr   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (clr_req) begin
                    state_n = S_CLEAR;
                    rc_clr  = 1'b1;
                end else if (req != 2'b00) begin
                    state_n  = S_BLOCK;
                    grant_go = 1'b1;
                    unique case (req)
                        2'b01:   grant_p = 1'b0;
                        2'b10:   grant_p = 1'b1;
                        default: grant_p = ~last_grant;
                    endcase
                end
            end
            S_BLOCK: begin
                if (cnt == CNT_LAST)
                    state_n = S_DONE;
            end
            S_CLEAR: begin
                rc_en = 1'b1;
                if (rc_last)
                    state_n = S_DONE;
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Latch the granted block and step the block pixel counter.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            bx         <= '0;
            by         <= '0;
            bc         <= '0;
            cnt        <= '0;
            gnt        <= 1'b0;
            last_grant <= 1'b1;
            clr_job    <= 1'b0;
        end else begin
            if (grant_go) begin
                bx         <= grant_p ? p1_x : p0_x;
                by         <= grant_p ? p1_y : p0_y;
                bc         <= grant_p ? p1_colour : p0_colour;
                gnt        <= grant_p;
                last_grant <= grant_p;
                cnt        <= '0;
                clr_job    <= 1'b0;
            end else if (state == S_BLOCK) begin
                cnt <= cnt + 1'b1;
            end
            if (rc_clr)
                clr_job <= 1'b1;
        end
    end

    // Adapter outputs and completion pulses, decoded from state.
    always_comb begin
        x        = '0;
        y        = '0;
        colour   = '0;
        plot     = 1'b0;
        done     = 2'b00;
        clr_done = 1'b0;
        unique case (state)
            S_BLOCK: begin
                x      = sum_x[7:0];
                y      = sum_y[6:0];
                colour = bc;
                plot   = ~clip;
            end
            S_CLEAR: begin
                x      = rx;
                y      = ry;
                colour = CLEAR_COLOUR;
                plot   = 1'b1;
            end
            S_DONE: begin
                if (clr_job)
                    clr_done = 1'b1;
                else
                    done[gnt] = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Scoreboard bench for vga_plot_arbiter.
// Expected pixels and completion pulses come from a reference model.
module tb_vga_plot_arbiter;

    logic       clk = 1'b0;
    logic       resetn;
    logic [1:0] req;
    logic [7:0] p0_x;
    logic [6:0] p0_y;
    logic [2:0] p0_colour;
    logic [7:0] p1_x;
    logic [6:0] p1_y;
    logic [2:0] p1_colour;
    logic       clr_req;
    logic [1:0] done;
    logic       clr_done;
    logic       busy;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [17:0] exp_pix[$];
    logic [2:0]  exp_done[$];
    int mlast = 1;

    vga_plot_arbiter dut (
        .clk(clk),
        .resetn(resetn),
        .req(req),
        .p0_x(p0_x),
        .p0_y(p0_y),
        .p0_colour(p0_colour),
        .p1_x(p1_x),
        .p1_y(p1_y),
        .p1_colour(p1_colour),
        .clr_req(clr_req),
        .done(done),
        .clr_done(clr_done),
        .busy(busy),
        .x(x),
        .y(y),
        .colour(colour),
        .plot(plot)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Model: one player block, 4x4 row-major, off-screen pixels skipped.
    task automatic model_block(input int p);
        int bx0, by0;
        logic [2:0] c;
        bx0 = (p == 0) ? int'(p0_x) : int'(p1_x);
        by0 = (p == 0) ? int'(p0_y) : int'(p1_y);
        c = (p == 0) ? p0_colour : p1_colour;
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < 4; i++)
                if (bx0 + i < 160 && by0 + j < 120)
                    exp_pix.push_back({8'(bx0 + i), 7'(by0 + j), c});
        exp_done.push_back((p == 0) ? 3'b001 : 3'b010);
        mlast = p;
    endtask

    // Model: clear sweep, optionally cut short after n pixels.
    task automatic model_clear(input int n);
        int k;
        k = 0;
        for (int j = 0; j < 120; j++)
            for (int i = 0; i < 160; i++) begin
                if (k < n)
                    exp_pix.push_back({8'(i), 7'(j), 3'b000});
                k++;
            end
        if (n >= 19200)
            exp_done.push_back(3'b100);
    endtask

    // Model: service order for a set of simultaneously raised requests.
    task automatic model_txn(input logic [1:0] r, input logic c);
        int first;
        if (c)
            model_clear(19200);
        if (r == 2'b11) begin
            first = 1 - mlast;
            model_block(first);
            model_block(1 - first);
        end else if (r == 2'b01) begin
            model_block(0);
        end else if (r == 2'b10) begin
            model_block(1);
        end
    endtask

    // Monitor: compare every plotted pixel and every completion pulse.
    always @(negedge clk) begin
        logic [17:0] e;
        logic [2:0] d;
        if (plot === 1'b1) begin
            total++;
            if (exp_pix.size() == 0) begin
                bad++;
                $display("FAIL extra_plot got=(%0d,%0d,%0d) want=none",
                         x, y, colour);
            end else begin
                e = exp_pix.pop_front();
                if ({x, y, colour} !== e) begin
                    bad++;
                    $display("FAIL pixel got=(%0d,%0d,%0d) want=(%0d,%0d,%0d)",
                             x, y, colour, e[17:10], e[9:3], e[2:0]);
                end
            end
        end
        if (({clr_done, done} !== 3'b000) && ({clr_done, done} !== 3'bxxx)) begin
            total++;
            if (exp_done.size() == 0) begin
                bad++;
                $display("FAIL extra_done got=%b want=none", {clr_done, done});
            end else begin
                d = exp_done.pop_front();
                if ({clr_done, done} !== d) begin
                    bad++;
                    $display("FAIL done got=%b want=%b", {clr_done, done}, d);
                end
            end
        end
    end

    // Requester: raise requests, drop each on the edge after its done.
    task automatic do_txn(input logic [1:0] r, input logic c,
                          input int lat, input int chg);
        logic [1:0] pr;
        logic pcl;
        int t0;
        int n;
        bit seen;
        model_txn(r, c);
        @(posedge clk);
        #1;
        req = r;
        clr_req = c;
        pr = r;
        pcl = c;
        t0 = cyc;
        n = 0;
        seen = 0;
        while ((pr != 2'b00 || pcl) && n < 25000) begin
            @(negedge clk);
            n++;
            if (done != 2'b00 || clr_done) begin
                if (!seen && lat > 0) begin
                    total++;
                    if (cyc - t0 != lat) begin
                        bad++;
                        $display("FAIL latency got=%0d want=%0d", cyc - t0, lat);
                    end
                end
                seen = 1;
            end
            pr = pr & ~done;
            if (clr_done)
                pcl = 1'b0;
            @(posedge clk);
            #1;
            if (chg > 0 && cyc - t0 == chg)
                p0_x = 8'd90;
            req = pr;
            clr_req = pcl;
        end
        if (n >= 25000) begin
            total++;
            bad++;
            $display("FAIL timeout got=pending want=done");
            req = 2'b00;
            clr_req = 1'b0;
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_after got=%b want=0", busy);
        end
    endtask

    initial begin
        int t0;
        resetn = 1'b0;
        req = 2'b00;
        clr_req = 1'b0;
        p0_x = 8'd0;
        p0_y = 7'd0;
        p0_colour = 3'd0;
        p1_x = 8'd0;
        p1_y = 7'd0;
        p1_colour = 3'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({plot, done, clr_done, busy, x, y, colour} !== 23'd0) begin
            bad++;
            $display("FAIL reset_outs got=%b want=0",
                     {plot, done, clr_done, busy, x, y, colour});
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;

        p0_x = 8'd10; p0_y = 7'd20; p0_colour = 3'b100;
        do_txn(2'b01, 1'b0, 17, 0);

        p0_x = 8'd10; p0_y = 7'd40; p0_colour = 3'b011;
        do_txn(2'b01, 1'b0, 17, 2);

        p1_x = 8'd158; p1_y = 7'd118; p1_colour = 3'b110;
        do_txn(2'b10, 1'b0, 17, 0);

        p0_x = 8'd0; p0_y = 7'd0; p0_colour = 3'b001;
        p1_x = 8'd100; p1_y = 7'd50; p1_colour = 3'b010;
        do_txn(2'b11, 1'b0, 17, 0);
        do_txn(2'b11, 1'b0, 17, 0);
        p0_x = 8'd20;
        do_txn(2'b11, 1'b0, 17, 0);

        p0_x = 8'd30; p0_y = 7'd60; p0_colour = 3'b101;
        do_txn(2'b01, 1'b1, 19201, 0);

        model_clear(30 * 160 + 51);
        mlast = 1;
        @(posedge clk);
        #1;
        clr_req = 1'b1;
        t0 = cyc;
        while (cyc - t0 < 4851) begin
            @(posedge clk);
            #1;
        end
        resetn = 1'b0;
        clr_req = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        total++;
        if (plot !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset got=plot%b busy%b want=plot0 busy0",
                     plot, busy);
        end
        p0_x = 8'd5; p0_y = 7'd5; p0_colour = 3'b111;
        p1_x = 8'd70; p1_y = 7'd90; p1_colour = 3'b001;
        do_txn(2'b11, 1'b0, 17, 0);

        for (int k = 0; k < 20; k++) begin
            logic [1:0] r;
            r = 2'($urandom_range(1, 3));
            p0_x = 8'($urandom_range(0, 159));
            p0_y = 7'($urandom_range(0, 119));
            p0_colour = 3'($urandom);
            p1_x = 8'($urandom_range(150, 159));
            p1_y = 7'($urandom_range(0, 119));
            p1_colour = 3'($urandom);
            do_txn(r, 1'b0, 17, 0);
        end

        repeat (3) @(negedge clk);
        total++;
        if (exp_pix.size() != 0) begin
            bad++;
            $display("FAIL pix_left got=%0d want=0", exp_pix.size());
        end
        total++;
        if (exp_done.size() != 0) begin
            bad++;
            $display("FAIL done_left got=%0d want=0", exp_done.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
